// File: rtl/gy25_frame_rx.sv
// GY-25 receive path: 8N1 UART deserializer feeding a parser for the
// 8-byte attitude frame (AA, yaw, pitch, roll, 55).
module gy25_frame_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        TX232,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [15:0] yaw,
  output logic [15:0] pitch,
  output logic [15:0] roll,
  output logic        frame_valid,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic [1:0] {P_HUNT, P_BODY, P_TAIL} parse_state_e;

  logic sync1_q, sync2_q, rx_d1_q;
  logic rx_s, fall;

  uart_state_e  ustate_q, ustate_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [7:0]   shift_q, shift_d;
  logic         stop_err_q, stop_err_d;
  logic [7:0]   byte_data_q, byte_data_d;
  logic         byte_valid_q, byte_valid_d;
  logic         ferr;

  parse_state_e pstate_q, pstate_d;
  logic [2:0]   idx_q, idx_d;
  logic [47:0]  hold_q, hold_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic         tmo_hit;
  logic [15:0]  yaw_q, yaw_d, pitch_q, pitch_d, roll_q, roll_d;
  logic         frame_valid_q, frame_valid_d;
  logic         frame_err_q, frame_err_d;

  assign rx_s = sync2_q;
  assign fall = rx_d1_q & ~sync2_q;

  always_comb begin
    ustate_d     = ustate_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    stop_err_d   = stop_err_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    ferr         = 1'b0;
    case (ustate_q)
      U_IDLE: begin
        if (fall) begin
          ustate_d = U_START;
          cnt_d    = '0;
        end
      end
      U_START: begin
        if (cnt_q == HALF_BIT) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          ustate_d  = rx_s ? U_IDLE : U_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) ustate_d = U_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      U_STOP: begin
        // After a bad stop bit, park here until the line recovers high.
        if (stop_err_q) begin
          if (rx_s) begin
            stop_err_d = 1'b0;
            ustate_d   = U_IDLE;
          end
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            ustate_d     = U_IDLE;
          end else begin
            ferr       = 1'b1;
            stop_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ustate_d = U_IDLE;
    endcase
  end

  // Counter holds cycles since the last byte, so the abort lands
  // TIMEOUT_CLKS cycles after that byte's strobe.
  assign tmo_hit = (pstate_q != P_HUNT) && !byte_valid_q && (tmo_q == TMO_LAST);

  always_comb begin
    pstate_d      = pstate_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    yaw_d         = yaw_q;
    pitch_d       = pitch_q;
    roll_d        = roll_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    if (byte_valid_q) tmo_d = TW'(1);
    else if (pstate_q != P_HUNT) tmo_d = tmo_q + 1'b1;
    else tmo_d = '0;

    if (ferr || tmo_hit) begin
      pstate_d    = P_HUNT;
      frame_err_d = 1'b1;
    end else if (byte_valid_q) begin
      case (pstate_q)
        P_HUNT: begin
          if (byte_data_q == 8'hAA) begin
            pstate_d = P_BODY;
            idx_d    = '0;
          end
        end
        P_BODY: begin
          hold_d = {hold_q[39:0], byte_data_q};
          idx_d  = idx_q + 3'd1;
          if (idx_q == 3'd5) pstate_d = P_TAIL;
        end
        P_TAIL: begin
          if (byte_data_q == 8'h55) begin
            yaw_d         = hold_q[47:32];
            pitch_d       = hold_q[31:16];
            roll_d        = hold_q[15:0];
            frame_valid_d = 1'b1;
            pstate_d      = P_HUNT;
          end else if (byte_data_q == 8'hAA) begin
            frame_err_d = 1'b1;
            pstate_d    = P_BODY;
            idx_d       = '0;
          end else begin
            frame_err_d = 1'b1;
            pstate_d    = P_HUNT;
          end
        end
        default: pstate_d = P_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      rx_d1_q       <= 1'b1;
      ustate_q      <= U_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      stop_err_q    <= 1'b0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      pstate_q      <= P_HUNT;
      idx_q         <= '0;
      hold_q        <= '0;
      tmo_q         <= '0;
      yaw_q         <= '0;
      pitch_q       <= '0;
      roll_q        <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      sync1_q       <= TX232;
      sync2_q       <= sync1_q;
      rx_d1_q       <= sync2_q;
      ustate_q      <= ustate_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      stop_err_q    <= stop_err_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      pstate_q      <= pstate_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      tmo_q         <= tmo_d;
      yaw_q         <= yaw_d;
      pitch_q       <= pitch_d;
      roll_q        <= roll_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign yaw         = yaw_q;
  assign pitch       = pitch_q;
  assign roll        = roll_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;

endmodule
